psoc_audio_dma: RTL and testbench

Wishbone-master DMA engine feeding the PSoC audio sample FIFO. It reads stereo samples from system memory and packs each pair of 32-bit words into one 48-bit sample. It pushes each sample into the audio FIFO write port (`audio_data`/`audio_valid`), stalling while the FIFO reports full. This removes per-sample CPU writes: software programs a buffer base address and length, then either takes a single-shot `done` pulse or lets the engine loop over the buffer continuously.

---
 rtl/psoc_audio_dma.sv | 121 ++++++++++++
 tb/tb_psoc_audio_dma.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psoc_audio_dma.sv
// Wishbone-master DMA that fetches stereo word pairs from memory and pushes
// packed 48-bit samples into the audio FIFO, single-shot or looping.
module psoc_audio_dma #(
  parameter int LEN_BITS = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         cfg_base,
  input  logic [LEN_BITS-1:0] cfg_len,
  input  logic                cfg_loop,
  input  logic                cfg_start,
  input  logic                cfg_stop,
  output logic                busy,
  output logic                done,
  output logic [31:0]         wbm_adr_o,
  input  logic [31:0]         wbm_dat_i,
  output logic                wbm_we_o,
  output logic [3:0]          wbm_sel_o,
  output logic                wbm_cyc_o,
  output logic                wbm_stb_o,
  input  logic                wbm_ack_i,
  output logic [47:0]         audio_data,
  output logic                audio_valid,
  input  logic                fifo_full
);

  typedef enum logic [1:0] {IDLE, RD_L, RD_R, PUSH} state_e;

  state_e              state_q;
  logic [31:0]         ptr_q, base_q;
  logic [LEN_BITS-1:0] len_q, cnt_q;
  logic                loop_q, stop_q, done_q;
  logic [23:0]         left_q, right_q;
  logic                rd, last;
  logic                unused_bits;

  assign rd   = (state_q == RD_L) || (state_q == RD_R);
  assign last = (cnt_q + LEN_BITS'(1)) == len_q;

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign wbm_adr_o   = ptr_q;
  assign wbm_we_o    = 1'b0;
  assign wbm_sel_o   = 4'b1111;
  assign wbm_cyc_o   = rd;
  assign wbm_stb_o   = rd;
  assign audio_data  = {left_q, right_q};
  // An abort in PUSH must not leak a sample into the FIFO.
  assign audio_valid = (state_q == PUSH) && !fifo_full && !cfg_stop;

  assign unused_bits = ^{wbm_dat_i[31:24], cfg_base[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      base_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      loop_q  <= 1'b0;
      stop_q  <= 1'b0;
      done_q  <= 1'b0;
      left_q  <= '0;
      right_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cfg_start && !cfg_stop) begin
            base_q <= {cfg_base[31:2], 2'b00};
            ptr_q  <= {cfg_base[31:2], 2'b00};
            len_q  <= cfg_len;
            loop_q <= cfg_loop;
            cnt_q  <= '0;
            stop_q <= 1'b0;
            if (cfg_len == '0) done_q  <= 1'b1;
            else               state_q <= RD_L;
          end
        end
        RD_L, RD_R: begin
          if (cfg_stop) stop_q <= 1'b1;
          // A recorded abort lets the bus cycle finish, then drops the data.
          if (wbm_ack_i) begin
            if (stop_q || cfg_stop) begin
              stop_q  <= 1'b0;
              state_q <= IDLE;
            end else begin
              ptr_q <= ptr_q + 32'd4;
              if (state_q == RD_L) begin
                left_q  <= wbm_dat_i[23:0];
                state_q <= RD_R;
              end else begin
                right_q <= wbm_dat_i[23:0];
                state_q <= PUSH;
              end
            end
          end
        end
        PUSH: begin
          if (cfg_stop) begin
            state_q <= IDLE;
          end else if (!fifo_full) begin
            cnt_q <= cnt_q + LEN_BITS'(1);
            if (last && loop_q) begin
              ptr_q   <= base_q;
              cnt_q   <= '0;
              state_q <= RD_L;
            end else if (last) begin
              done_q  <= 1'b1;
              state_q <= IDLE;
            end else begin
              state_q <= RD_L;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_psoc_audio_dma.sv
// Directed + randomized bench for psoc_audio_dma with a memory slave model
// and a sample/address reference computed from buffer arithmetic.
module tb_psoc_audio_dma;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cfg_base;
  logic [15:0] cfg_len;
  logic        cfg_loop, cfg_start, cfg_stop;
  logic        busy, done;
  logic [31:0] wbm_adr_o, wbm_dat_i;
  logic        wbm_we_o, wbm_cyc_o, wbm_stb_o, wbm_ack_i;
  logic [3:0]  wbm_sel_o;
  logic [47:0] audio_data;
  logic        audio_valid, fifo_full;

  int total = 0, bad = 0;
  int cyc_n = 0, wcnt = 0, wait_n = 0, full_until = 0;
  bit rnd_en = 1'b0, rnd_full = 1'b0;

  psoc_audio_dma #(.LEN_BITS(16)) dut (
    .clk(clk), .rst(rst), .cfg_base(cfg_base), .cfg_len(cfg_len),
    .cfg_loop(cfg_loop), .cfg_start(cfg_start), .cfg_stop(cfg_stop),
    .busy(busy), .done(done), .wbm_adr_o(wbm_adr_o), .wbm_dat_i(wbm_dat_i),
    .wbm_we_o(wbm_we_o), .wbm_sel_o(wbm_sel_o), .wbm_cyc_o(wbm_cyc_o),
    .wbm_stb_o(wbm_stb_o), .wbm_ack_i(wbm_ack_i), .audio_data(audio_data),
    .audio_valid(audio_valid), .fifo_full(fifo_full)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h100: return 32'hAA123456;
      32'h104: return 32'hBB654321;
      32'h108: return 32'h00000001;
      32'h10C: return 32'h00FFFFFF;
      default: return (a * 32'h9E3779B1) ^ 32'h5A5AC3C3;
    endcase
  endfunction

  // Reference: sample idx lives at base + 8*idx (left) and +4 (right).
  function automatic logic [47:0] exp_sample(input logic [31:0] b, input int idx);
    logic [31:0] a, l, r;
    a = b + 32'(idx) * 32'd8;
    l = mem_word(a);
    r = mem_word(a + 32'd4);
    return {l[23:0], r[23:0]};
  endfunction

  function automatic logic [31:0] exp_addr(input logic [31:0] b, input int len, input bit lp, input int j);
    int s;
    s = j / 2;
    if (lp) s = s % len;
    return b + 32'(s) * 32'd8 + 32'(j % 2) * 32'd4;
  endfunction

  assign fifo_full = (cyc_n < full_until) || rnd_full;
  assign wbm_ack_i = wbm_stb_o && (wcnt == wait_n);
  assign wbm_dat_i = mem_word(wbm_adr_o);

  always @(posedge clk) begin
    cyc_n    <= cyc_n + 1;
    wcnt     <= (wbm_stb_o && !wbm_ack_i) ? wcnt + 1 : 0;
    rnd_full <= rnd_en && ($urandom_range(0, 2) == 0);
  end

  logic [31:0] addr_q[$];
  logic [47:0] data_q[$];
  int pt_q[$], done_c[$];
  int stb_n = 0, viol = 0, clr_gen = 0, clr_seen = 0;

  always @(negedge clk) begin
    if (clr_gen != clr_seen) begin
      addr_q.delete(); data_q.delete(); pt_q.delete(); done_c.delete();
      stb_n = 0; viol = 0; clr_seen = clr_gen;
    end
    if (wbm_stb_o === 1'b1) stb_n++;
    if (wbm_stb_o === 1'b1 && wbm_ack_i === 1'b1) addr_q.push_back(wbm_adr_o);
    if (audio_valid === 1'b1) begin data_q.push_back(audio_data); pt_q.push_back(cyc_n); end
    if (done === 1'b1) done_c.push_back(cyc_n);
    if ((audio_valid === 1'b1 && fifo_full === 1'b1) || (done === 1'b1 && busy !== 1'b0) ||
        (wbm_cyc_o !== wbm_stb_o) || (wbm_we_o !== 1'b0) || (wbm_sel_o !== 4'hF))
      viol++;
  end

  function automatic logic [47:0] qd(input int i);
    if (i < data_q.size()) return data_q[i];
    return 'x;
  endfunction
  function automatic logic [31:0] qa(input int i);
    if (i < addr_q.size()) return addr_q[i];
    return 'x;
  endfunction
  function automatic int qp(input int i);
    if (i < pt_q.size()) return pt_q[i];
    return -1;
  endfunction
  function automatic int qdn(input int i);
    if (i < done_c.size()) return done_c[i];
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear();
    clr_gen++;
    @(negedge clk); #1;
  endtask

  task automatic start(input logic [31:0] b, input logic [15:0] l, input logic lp, output int k);
    @(posedge clk); #1;
    cfg_base = b; cfg_len = l; cfg_loop = lp; cfg_start = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    k = cyc_n;
    cfg_base = $urandom; cfg_len = 16'($urandom); cfg_loop = 1'($urandom);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin @(posedge clk); #1; n++; end
    chk({tag, " idle"}, 64'(busy), 64'(0));
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic check_run(input string tag, input logic [31:0] b, input int len,
                           input bit lp, input int n, input bit exact);
    chk({tag, " pushes"}, 64'(data_q.size()), 64'(n));
    for (int i = 0; i < n; i++)
      chk({tag, " data"}, 64'(qd(i)), 64'(exp_sample(b, lp ? i % len : i)));
    if (exact) chk({tag, " reads"}, 64'(addr_q.size()), 64'(2 * n));
    for (int j = 0; j < 2 * n; j++)
      chk({tag, " addr"}, 64'(qa(j)), 64'(exp_addr(b, len, lp, j)));
    chk({tag, " protocol"}, 64'(viol), 64'(0));
  endtask

  initial begin
    int k, n, len;
    logic [31:0] b;
    rst = 1'b1; cfg_base = '0; cfg_len = '0; cfg_loop = 1'b0; cfg_start = 1'b0; cfg_stop = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst busy", 64'(busy), 64'(0));
    chk("rst done", 64'(done), 64'(0));
    chk("rst cyc", 64'(wbm_cyc_o), 64'(0));
    chk("rst stb", 64'(wbm_stb_o), 64'(0));
    chk("rst adr", 64'(wbm_adr_o), 64'(0));
    chk("rst valid", 64'(audio_valid), 64'(0));
    chk("rst data", 64'(audio_data), 64'(0));
    chk("rst sel", 64'(wbm_sel_o), 64'hF);
    rst = 1'b0;

    // single shot, zero wait
    clear();
    start(32'h100, 16'd2, 1'b0, k);
    wait_idle(60, "t1");
    check_run("t1", 32'h100, 2, 1'b0, 2, 1'b1);
    chk("t1 s0", 64'(qd(0)), 64'h123456654321);
    chk("t1 s1", 64'(qd(1)), 64'h000001FFFFFF);
    chk("t1 a3", 64'(qa(3)), 64'h10C);
    chk("t1 push0 t", 64'(qp(0)), 64'(k + 2));
    chk("t1 push1 t", 64'(qp(1)), 64'(k + 5));
    chk("t1 done t", 64'(qdn(0)), 64'(k + 6));
    chk("t1 done n", 64'(done_c.size()), 64'(1));

    // two wait states per read, FIFO full for the first 5 PUSH cycles
    wait_n = 2;
    b = 32'h4000 + {$urandom_range(0, 255), 3'b000};
    clear();
    start(b, 16'd2, 1'b0, k);
    full_until = k + 11;
    wait_idle(100, "t2");
    full_until = 0;
    check_run("t2", b, 2, 1'b0, 2, 1'b1);
    chk("t2 push0 t", 64'(qp(0)), 64'(k + 11));
    chk("t2 push1 t", 64'(qp(1)), 64'(k + 18));
    chk("t2 done t", 64'(qdn(0)), 64'(k + 19));

    // loop over 3 samples, stop after 8 pushes
    wait_n = 0;
    b = 32'h8000 + {$urandom_range(0, 255), 2'b00};
    clear();
    start(b, 16'd3, 1'b1, k);
    n = 0;
    while (data_q.size() < 8 && n < 200) begin @(posedge clk); #1; n++; end
    chk("t3 reached 8", 64'(data_q.size() >= 8), 64'(1));
    cfg_stop = 1'b1;
    @(posedge clk); #1;
    cfg_stop = 1'b0;
    wait_idle(20, "t3");
    check_run("t3", b, 3, 1'b1, 8, 1'b0);
    chk("t3 no done", 64'(done_c.size()), 64'(0));

    // stop while RD_R waits on a slow ack; a start during the wait is ignored
    wait_n = 3;
    b = 32'hC000;
    clear();
    start(b, 16'd2, 1'b0, k);
    while (cyc_n < k + 4) begin @(posedge clk); #1; end
    cfg_stop = 1'b1;
    @(posedge clk); #1;
    cfg_stop = 1'b0; cfg_start = 1'b1; cfg_len = 16'd1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    wait_idle(20, "t4");
    repeat (4) @(posedge clk);
    #1;
    chk("t4 stb cycles", 64'(stb_n), 64'(8));
    chk("t4 reads", 64'(addr_q.size()), 64'(2));
    chk("t4 no push", 64'(data_q.size()), 64'(0));
    chk("t4 no done", 64'(done_c.size()), 64'(0));
    chk("t4 busy", 64'(busy), 64'(0));

    // stop and start together in IDLE
    wait_n = 0;
    clear();
    @(posedge clk); #1;
    cfg_start = 1'b1; cfg_stop = 1'b1; cfg_len = 16'd2; cfg_base = 32'h500;
    @(posedge clk); #1;
    cfg_start = 1'b0; cfg_stop = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("t5 busy", 64'(busy), 64'(0));
    chk("t5 stb", 64'(stb_n), 64'(0));
    chk("t5 done", 64'(done_c.size()), 64'(0));

    // zero length
    clear();
    start(32'h300, 16'd0, 1'b0, k);
    repeat (3) @(negedge clk);
    #1;
    chk("t6 done t", 64'(qdn(0)), 64'(k));
    chk("t6 done n", 64'(done_c.size()), 64'(1));
    chk("t6 stb", 64'(stb_n), 64'(0));
    chk("t6 busy", 64'(busy), 64'(0));

    // address wrap
    clear();
    start(32'hFFFFFFF8, 16'd2, 1'b0, k);
    wait_idle(60, "t7");
    check_run("t7", 32'hFFFFFFF8, 2, 1'b0, 2, 1'b1);
    chk("t7 a2", 64'(qa(2)), 64'h0);
    chk("t7 a3", 64'(qa(3)), 64'h4);

    // start while busy is ignored
    clear();
    start(32'h600, 16'd2, 1'b0, k);
    @(posedge clk); #1;
    cfg_base = 32'h900; cfg_len = 16'd5; cfg_start = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    wait_idle(60, "t8");
    check_run("t8", 32'h600, 2, 1'b0, 2, 1'b1);
    chk("t8 done n", 64'(done_c.size()), 64'(1));

    // randomized runs: unaligned bases, wait states, random FIFO back-pressure
    for (int it = 0; it < 6; it++) begin
      wait_n = $urandom_range(0, 2);
      rnd_en = 1'($urandom_range(0, 1));
      b = $urandom;
      len = $urandom_range(1, 5);
      clear();
      start(b, 16'(len), 1'b0, k);
      wait_idle(400, "rnd");
      rnd_en = 1'b0;
      check_run("rnd", {b[31:2], 2'b00}, len, 1'b0, len, 1'b1);
      chk("rnd done n", 64'(done_c.size()), 64'(1));
      chk("rnd done t", 64'(qdn(0)), 64'(qp(len - 1) + 1));
      @(posedge clk); #1;
    end

    // reset while stalled in PUSH, then a clean restart
    wait_n = 0;
    clear();
    start(32'hA000, 16'd2, 1'b0, k);
    full_until = k + 100;
    while (cyc_n < k + 4) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    full_until = 0;
    chk("t10 busy", 64'(busy), 64'(0));
    chk("t10 cyc", 64'(wbm_cyc_o), 64'(0));
    chk("t10 valid", 64'(audio_valid), 64'(0));
    chk("t10 data", 64'(audio_data), 64'(0));
    chk("t10 adr", 64'(wbm_adr_o), 64'(0));
    chk("t10 done", 64'(done), 64'(0));
    chk("t10 no push", 64'(data_q.size()), 64'(0));
    clear();
    start(32'hB004, 16'd1, 1'b0, k);
    wait_idle(60, "t10b");
    check_run("t10b", 32'hB004, 1, 1'b0, 1, 1'b1);
    chk("t10b done t", 64'(qdn(0)), 64'(k + 3));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
